// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register: control + data bundle behind a valid/ready
// handshake, optional skid entry, hold/flush bubble insertion and perf counters.
module pipe_stage_reg #(
    parameter int                 DATA_W   = 64,
    parameter int                 CTRL_W   = 8,
    parameter logic [CTRL_W-1:0]  CTRL_NOP = '0,
    parameter int                 SKID     = 1,
    parameter int                 CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    input  logic              hold,
    input  logic              flush,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    // State encoding doubles as the entry valid bits: {M.v, S.v}.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b10,
        ST_FULL  = 2'b11
    } state_t;

    state_t             state_reg, state_next;
    logic [CTRL_W-1:0]  m_ctrl_reg, m_ctrl_next;
    logic [DATA_W-1:0]  m_data_reg, m_data_next;
    logic [CTRL_W-1:0]  s_ctrl_reg, s_ctrl_next;
    logic [DATA_W-1:0]  s_data_reg, s_data_next;
    logic [CNT_W-1:0]   stall_cnt_reg, bubble_cnt_reg;

    logic m_v, s_v, gate, acc, emit, stall_inc, bubble_inc;

    assign m_v  = state_reg[1];
    assign s_v  = state_reg[0];
    assign gate = ~hold & ~flush;

    assign out_valid = m_v & gate;
    assign out_ctrl  = m_ctrl_reg;
    assign out_data  = m_data_reg;

    generate
        if (SKID != 0) begin : g_skid
            // Depends only on registered state plus hold/flush: no out_ready path.
            assign in_ready = ~s_v & gate & ~rst;
        end else begin : g_pass
            assign in_ready = (~m_v | out_ready) & gate & ~rst;
        end
    endgenerate

    assign acc  = in_valid & in_ready;
    assign emit = out_valid & out_ready;

    assign stall_inc  = m_v & ~flush & (hold | ~out_ready);
    assign bubble_inc = out_ready & ~m_v & gate;

    always_comb begin
        state_next  = state_reg;
        m_ctrl_next = m_ctrl_reg;
        m_data_next = m_data_reg;
        s_ctrl_next = s_ctrl_reg;
        s_data_next = s_data_reg;
        if (flush) begin
            state_next  = ST_EMPTY;
            m_ctrl_next = CTRL_NOP;
            m_data_next = '0;
            s_ctrl_next = CTRL_NOP;
            s_data_next = '0;
        end else if (!hold) begin
            case (state_reg)
                ST_EMPTY: begin
                    if (acc) begin
                        state_next  = ST_ONE;
                        m_ctrl_next = in_ctrl;
                        m_data_next = in_data;
                    end
                end
                ST_ONE: begin
                    if (acc && emit) begin
                        m_ctrl_next = in_ctrl;
                        m_data_next = in_data;
                    end else if (acc && (SKID != 0)) begin
                        state_next  = ST_FULL;
                        s_ctrl_next = in_ctrl;
                        s_data_next = in_data;
                    end else if (emit) begin
                        state_next  = ST_EMPTY;
                        m_ctrl_next = CTRL_NOP;
                        m_data_next = '0;
                    end
                end
                ST_FULL: begin
                    if (emit) begin
                        state_next  = ST_ONE;
                        m_ctrl_next = s_ctrl_reg;
                        m_data_next = s_data_reg;
                        s_ctrl_next = CTRL_NOP;
                        s_data_next = '0;
                    end
                end
                default: begin
                    state_next  = ST_EMPTY;
                    m_ctrl_next = CTRL_NOP;
                    m_data_next = '0;
                    s_ctrl_next = CTRL_NOP;
                    s_data_next = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_EMPTY;
            m_ctrl_reg     <= CTRL_NOP;
            m_data_reg     <= '0;
            s_ctrl_reg     <= CTRL_NOP;
            s_data_reg     <= '0;
            stall_cnt_reg  <= '0;
            bubble_cnt_reg <= '0;
        end else begin
            state_reg  <= state_next;
            m_ctrl_reg <= m_ctrl_next;
            m_data_reg <= m_data_next;
            s_ctrl_reg <= s_ctrl_next;
            s_data_reg <= s_data_next;
            if (stall_inc && (stall_cnt_reg != {CNT_W{1'b1}}))
                stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
            if (bubble_inc && (bubble_cnt_reg != {CNT_W{1'b1}}))
                bubble_cnt_reg <= bubble_cnt_reg + CNT_W'(1);
        end
    end

    assign stall_cnt  = stall_cnt_reg;
    assign bubble_cnt = bubble_cnt_reg;

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic, parametrised pipeline stage register for the 5-stage core; it replaces the per-stage hand-written IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Carries a data bundle and a control bundle, using a valid/ready handshake with an optional skid entry.
- Hold (stall) and flush inputs insert NOP bubbles.
- Stall and bubble cycles are counted for performance analysis.

Parameters:
- DATA_W, 64: width of the data bundle (PC, operands, immediates).
- CTRL_W, 8: width of the control bundle (RegWrite, MemRead, ...).
- CTRL_NOP, 0: control value presented and loaded when a stage is empty or flushed.
- SKID, 1: 1 gives a 2-entry skid buffer with registered in_ready; 0 gives a single entry with combinational pass-through ready.
- CNT_W, 16: width of each saturating performance counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  stage can accept a beat this cycle.
- in_ctrl  in  CTRL_W  upstream control bundle.
- in_data  in  DATA_W  upstream data bundle.
- out_valid  out  1  downstream beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_ctrl  out  CTRL_W  registered control; equals CTRL_NOP when the stage is empty.
- out_data  out  DATA_W  registered data; equals 0 when the stage is empty.
- hold  in  1  freeze the stage (load-use stall).
- flush  in  1  discard all held beats (branch/jump redirect).
- stall_cnt  out  CNT_W  cycles a valid beat was blocked.
- bubble_cnt  out  CNT_W  cycles downstream was ready but no beat was presented.

Behaviour:
- Clock and reset: one clock, clk. Reset is rst, synchronous and active-high, with highest priority.
- Reset values: M.v=0, S.v=0, all ctrl=CTRL_NOP, all data=0, stall_cnt=0, bubble_cnt=0. Consequently out_valid=0, out_ctrl=CTRL_NOP, out_data=0, and in_ready=0 during rst.
- Storage: main entry M (v, ctrl, data). When SKID=1 there is also a skid entry S (v, ctrl, data).
- Output drive: out_ctrl and out_data come directly from M. When M.v=0 they equal CTRL_NOP and 0.
- out_valid = M.v & ~hold & ~flush.
- Handshake terms: acc = in_valid & in_ready; emit = out_valid & out_ready. A beat transfers only on acc or emit.
- in_ready when SKID=1: ~S.v & ~hold & ~flush. This is registered state apart from hold/flush gating, so there is no out_ready-to-in_ready combinational path.
- in_ready when SKID=0: (~M.v | out_ready) & ~hold & ~flush.
- State machine, SKID=1, from (M.v, S.v):
  - EMPTY (0,0): acc -> ONE, M<=in.
  - ONE (1,0):
    - acc&emit -> ONE, M<=in.
    - acc&~emit -> FULL, S<=in.
    - ~acc&emit -> EMPTY.
    - neither -> ONE.
  - FULL (1,1): in_ready=0. emit -> ONE, M<=S, S cleared. No emit -> FULL.
- Ordering: beats leave in arrival order. No beat is ever dropped or duplicated except by flush.
- SKID=0 transitions:
  - acc -> M<=in, M.v=1.
  - emit&~acc -> M.v<=0 (ctrl<=CTRL_NOP, data<=0).
  - Simultaneous acc and emit refills M in the same cycle. Full throughput is one beat per cycle.
- hold=1 (and flush=0):
  - in_ready=0 and out_valid=0.
  - M and S are unchanged.
  - Held beats resume unchanged the cycle after hold drops.
- flush=1:
  - Priority over hold and the handshakes.
  - in_ready=0 and out_valid=0 in that cycle.
  - At the edge: M.v, S.v<=0, ctrl<=CTRL_NOP, data<=0.
  - An in_valid beat in the flush cycle is not accepted.
- Flush and hold together: flush wins.
- stall_cnt increments when (M.v & ~out_ready & ~hold & ~flush) | (M.v & hold & ~flush).
- bubble_cnt increments when out_ready & ~M.v & ~hold & ~flush.
- Counters saturate at 2^CNT_W-1 with no wrap, and are cleared only by rst.
- Latency: one cycle from acc to out_valid when M was empty or being emitted. A beat that lands in S waits one extra cycle.

Test Plan:
- Stream of 8 beats, ctrl=1..8, out_ready=1 throughout, SKID=1 -> out_valid from cycle 1 to cycle 8; outputs ctrl 1..8 in order; stall_cnt=0.
- Back-pressure, SKID=1: 3 beats offered while out_ready=0 -> 2 accepted (FULL); in_ready=0 in the cycle after the second acceptance; stall_cnt counts each blocked cycle. Raise out_ready -> beats leave as ctrl 1,2, then 3, with no loss.
- hold=1 for 3 cycles with M holding ctrl=0x5A, data=0x1234 -> out_valid=0 and in_ready=0 throughout; ctrl and data unchanged; after release, out_valid=1 with the same values.
- flush in FULL state, with in_valid=1 and hold=1 in the same cycle -> next cycle out_valid=0, out_ctrl=CTRL_NOP, out_data=0, in_ready=1; the flushed and offered beats never appear at the output.
- rst asserted mid-stream with counters non-zero -> next cycle every output at its reset value and both counters 0. With CNT_W=4, 20 blocked cycles -> stall_cnt holds at 15.
- SKID=0: out_ready=1 with in_valid every cycle -> one beat per cycle with same-cycle refill. Then out_ready=0 -> in_ready drops combinationally in the same cycle.
